mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Downstream of the multicycle main decoder.
- Consumes its memory-side controls (iord-selected address, memwrite, irwrite, lb[1:0]) and performs the access against a variable-latency unified memory over a req/ready handshake.
- Holds the instruction register (IR) and memory data register (MDR).
- Performs LB/LBU byte extraction and extension, and stalls the decoder FSM until each access completes.

Parameters:
- AW, 32, byte-address width.
- DW, 32, data width; fixed at 32.
- TIMEOUT, 64, WAIT cycles without mem_ready before the access is aborted.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- rd_req  in  1  read requested by current FSM state (FETCH, MEMRD, LBRD, LBURD); level, held while stall=1
- wr_req  in  1  memwrite from decoder; level, held while stall=1
- irwrite  in  1  read data targets IR instead of MDR
- lb  in  2  00 word, 01 LBU (zero-extend), 10 LB (sign-extend), 11 treated as word
- addr  in  AW  byte address (PC or ALUOut per iord)
- wdata  in  DW  store data (register B)
- stall  out  1  decoder must hold state while high
- instr  out  DW  IR contents
- mdr  out  DW  MDR contents
- err_timeout  out  1  sticky access-timeout flag
- err_misalign  out  1  sticky word-access misalignment flag
- mem_req  out  1  memory request, held until accepted
- mem_we  out  1  write enable, qualified by mem_req
- mem_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
- mem_wdata  out  DW  store data
- mem_ready  in  1  memory completion; read data valid in the same cycle
- mem_rdata  in  DW  memory read data

Behaviour:
- Reset: state IDLE; stall, mem_req and mem_we = 0; instr, mdr, mem_addr and mem_wdata = 0; both error flags = 0; timeout counter = 0. Reset mid-access aborts immediately; a late mem_ready after reset is ignored.
- States: IDLE, WAIT, DONE.
- IDLE:
  - If rd_req or wr_req: latch addr, wdata, lb, irwrite and direction; set mem_req=1 and mem_we=wr_req; go to WAIT.
  - If both requests are high, the write wins (rd ignored).
- WAIT:
  - mem_req held high with latched mem_addr, mem_we and mem_wdata stable.
  - Counter increments each cycle.
  - On mem_ready: drop mem_req and go to DONE.
    - Read with latched irwrite=1: instr <= mem_rdata.
    - Read with irwrite=0: mdr <= extracted value.
  - If the counter reaches TIMEOUT-1 without mem_ready: drop mem_req, set err_timeout, leave instr/mdr unchanged, go to DONE.
- DONE: one cycle, then unconditionally to IDLE. The request still visible this cycle is not re-issued.
- stall (combinational) = (IDLE and (rd_req or wr_req)) or WAIT. stall is 0 in DONE, so the FSM advances on the DONE→next edge.
- Latency: minimum 3 cycles per access (IDLE accept, WAIT with immediate ready, DONE).
- Byte extraction, little-endian; byte = mem_rdata[8*addr[1:0] +: 8]:
  - lb=01: mdr = {24'b0, byte}
  - lb=10: mdr = {{24{byte[7]}}, byte}
  - lb=00 or 11: mdr = mem_rdata
- Misalignment: a word access (lb=00/11, read or write) with addr[1:0]≠0 sets err_misalign; the access still proceeds at the aligned word. Byte loads never flag misalignment.
- Writes are word-only; instr and mdr are unchanged by writes.
- Error flags clear only on reset.

Test Plan:
- FETCH read, addr=0x0000_0004, irwrite=1, mem_ready asserted 2 cycles after mem_req → mem_addr=0x4, stall high for 3 cycles, instr=mem_rdata=0x2008_0005, mdr unchanged, stall low in DONE.
- LB at addr=0x0000_0103, mem_rdata=0x80FF_1234 → mdr=0xFFFF_FF80. Same access as LBU → mdr=0x0000_0080. mem_addr=0x100 in both cases.
- SW, addr=0x0000_0050, wdata=0xDEAD_BEEF, ready after 0 wait → mem_req=1, mem_we=1, mem_wdata=0xDEADBEEF, mdr/instr unchanged, access completes in 3 cycles.
- Word read at addr=0x0000_0006 → err_misalign=1, mem_addr=0x4, mdr=mem_rdata.
- mem_ready held low, TIMEOUT=8 → mem_req drops after 8 WAIT cycles, err_timeout=1, one DONE cycle with stall=0, instr/mdr unchanged.
- Assert reset during WAIT, then pulse mem_ready → all outputs return to reset values; the late ready produces no register update. Back-to-back requests (MEMWR followed by FETCH) each complete with their own DONE cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory access unit for the multicycle core: drives a req/ready unified memory,
// holds IR and MDR, extracts load bytes and stalls the decoder until each access retires.
module mem_access_unit #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rd_req,
  input  logic          wr_req,
  input  logic          irwrite,
  input  logic [1:0]    lb,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          stall,
  output logic [DW-1:0] instr,
  output logic [DW-1:0] mdr,
  output logic          err_timeout,
  output logic          err_misalign,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    lb_q;
  logic [1:0]    ofs_q;
  logic          irw_q;
  logic          start;
  logic          misalign;
  logic [7:0]    byte_sel;
  logic [DW-1:0] ext_val;

  // Accept decision, decoder stall and misalignment detection for the incoming request
  always_comb begin
    start    = (state == S_IDLE) && (rd_req || wr_req);
    stall    = start || (state == S_WAIT);
    // writes are always word accesses; loads are word accesses unless lb selects a byte
    misalign = (wr_req || (lb[0] == lb[1])) && (addr[1:0] != 2'b00);
  end

  // Little-endian byte pick and extension of read data according to the latched lb
  always_comb begin
    byte_sel = mem_rdata[{ofs_q, 3'b000} +: 8];
    case (lb_q)
      2'b01:   ext_val = {{(DW-8){1'b0}}, byte_sel};
      2'b10:   ext_val = {{(DW-8){byte_sel[7]}}, byte_sel};
      default: ext_val = mem_rdata;
    endcase
  end

  // Access FSM, memory-side registers, IR/MDR and sticky error flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      lb_q         <= 2'b00;
      ofs_q        <= 2'b00;
      irw_q        <= 1'b0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      instr        <= '0;
      mdr          <= '0;
      err_timeout  <= 1'b0;
      err_misalign <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mem_req   <= 1'b1;
            mem_we    <= wr_req;
            mem_addr  <= {addr[AW-1:2], 2'b00};
            mem_wdata <= wdata;
            lb_q      <= lb;
            ofs_q     <= addr[1:0];
            irw_q     <= irwrite;
            cnt       <= '0;
            if (misalign) begin
              err_misalign <= 1'b1;
            end
            state     <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) begin
              if (irw_q) begin
                instr <= mem_rdata;
              end else begin
                mdr <= ext_val;
              end
            end
            state <= S_DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            err_timeout <= 1'b1;
            state       <= S_DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized bench for mem_access_unit; a transaction-level model predicts
// IR/MDR, error flags, memory-side outputs and stall length of every access.
module tb_mem_access_unit;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_req, wr_req, irwrite;
  logic [1:0]  lb;
  logic [31:0] addr, wdata;
  logic        stall;
  logic [31:0] instr, mdr;
  logic        err_timeout, err_misalign;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  // model state
  logic [31:0] m_instr, m_mdr;
  logic        m_tmo, m_mis;

  mem_access_unit #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .wr_req(wr_req), .irwrite(irwrite), .lb(lb),
    .addr(addr), .wdata(wdata),
    .stall(stall), .instr(instr), .mdr(mdr),
    .err_timeout(err_timeout), .err_misalign(err_misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_regs(input string tag);
    chk({tag, ".instr"}, instr, m_instr);
    chk({tag, ".mdr"}, mdr, m_mdr);
    chk({tag, ".err_timeout"}, {31'd0, err_timeout}, {31'd0, m_tmo});
    chk({tag, ".err_misalign"}, {31'd0, err_misalign}, {31'd0, m_mis});
  endtask

  // One access from the IDLE point: memory answers ready on its d-th request cycle
  // (d >= TMO means it never answers). Requests stay high through DONE and one more edge.
  task automatic access(input string tag, input logic rd, input logic wr, input logic irw,
                        input logic [1:0] l, input logic [31:0] a, input logic [31:0] wd,
                        input int d, input logic [31:0] rdata);
    int k, cycles, exp_cycles;
    logic [31:0] bsel, ext;
    rd_req = rd; wr_req = wr; irwrite = irw; lb = l; addr = a; wdata = wd;
    mem_ready = 1'b0;
    #0;
    chk({tag, ".stall_accept"}, {31'd0, stall}, 32'd1);
    k = 0;
    cycles = 0;
    while (stall && cycles < 40) begin
      if (mem_req) begin
        if (k == 0) begin
          chk({tag, ".mem_addr"}, mem_addr, a & 32'hFFFF_FFFC);
          chk({tag, ".mem_we"}, {31'd0, mem_we}, {31'd0, wr});
          chk({tag, ".mem_wdata"}, mem_wdata, wd);
        end
        mem_ready = (k == d);
        mem_rdata = (k == d) ? rdata : $urandom;
        k++;
      end else begin
        mem_ready = 1'b0;
      end
      step();
      cycles++;
    end
    mem_ready = 1'b0;
    mem_rdata = $urandom;
    exp_cycles = (d < TMO) ? d + 2 : TMO + 1;
    chk({tag, ".stall_cycles"}, cycles, exp_cycles);
    // model update from the access rules
    if ((wr || l == 2'b00 || l == 2'b11) && a[1:0] != 2'b00) m_mis = 1'b1;
    if (d >= TMO) begin
      m_tmo = 1'b1;
    end else if (!wr) begin
      bsel = (rdata >> (8 * (a % 4))) & 32'hFF;
      if (l == 2'b01)      ext = bsel;
      else if (l == 2'b10) ext = (bsel >= 32'd128) ? (bsel | 32'hFFFF_FF00) : bsel;
      else                 ext = rdata;
      if (irw) m_instr = rdata;
      else     m_mdr = ext;
    end
    chk({tag, ".done_req"}, {31'd0, mem_req}, 32'd0);
    chk_regs(tag);
    step();
    chk({tag, ".no_reissue"}, {31'd0, mem_req}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    rd_req = 1'b0; wr_req = 1'b0; irwrite = 1'b0; lb = 2'b00;
    addr = 32'h0; wdata = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0;
    m_instr = 32'h0; m_mdr = 32'h0; m_tmo = 1'b0; m_mis = 1'b0;
    repeat (2) step();
    chk("rst.stall", {31'd0, stall}, 32'd0);
    chk("rst.mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk_regs("rst");
    reset = 1'b0;
    step();

    access("fetch", 1'b1, 1'b0, 1'b1, 2'b00, 32'h0000_0004, 32'h0, 1, 32'h2008_0005);
    access("lb",    1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0103, 32'h0, 0, 32'h80FF_1234);
    access("lbu",   1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_0103, 32'h0, 2, 32'h80FF_1234);
    access("sw",    1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_0050, 32'hDEAD_BEEF, 0, 32'h1111_1111);
    access("both",  1'b1, 1'b1, 1'b1, 2'b00, 32'h0000_0060, 32'h0BAD_F00D, 1, 32'h2222_2222);
    access("mis",   1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0006, 32'h0, 0, 32'hCAFE_0123);
    access("tmo",   1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0010, 32'h0, 99, 32'h3333_3333);
    access("edge7", 1'b1, 1'b0, 1'b1, 2'b00, 32'h0000_0020, 32'h0, TMO - 1, 32'h4444_4444);

    for (int i = 0; i < 24; i++) begin
      logic wr_r, irw_r;
      logic [1:0] lb_r;
      int d_r;
      wr_r  = ($urandom_range(0, 3) == 0);
      irw_r = $urandom_range(0, 1);
      lb_r  = $urandom_range(0, 3);
      d_r   = $urandom_range(0, TMO + 1);
      access($sformatf("rnd%0d", i), !wr_r, wr_r, irw_r, lb_r, $urandom, $urandom,
             d_r, $urandom);
    end

    // reset in the middle of WAIT, then a late ready must be ignored
    rd_req = 1'b1; wr_req = 1'b0; irwrite = 1'b0; lb = 2'b00; addr = 32'h0000_0044;
    step();
    step();
    chk("midrst.in_wait", {31'd0, mem_req}, 32'd1);
    rd_req = 1'b0;
    reset = 1'b1;
    #1;
    m_instr = 32'h0; m_mdr = 32'h0; m_tmo = 1'b0; m_mis = 1'b0;
    chk("midrst.stall", {31'd0, stall}, 32'd0);
    chk("midrst.mem_req", {31'd0, mem_req}, 32'd0);
    chk("midrst.mem_we", {31'd0, mem_we}, 32'd0);
    chk("midrst.mem_addr", mem_addr, 32'h0);
    chk("midrst.mem_wdata", mem_wdata, 32'h0);
    chk_regs("midrst");
    step();
    reset = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    step();
    mem_ready = 1'b0;
    step();
    chk("late.mem_req", {31'd0, mem_req}, 32'd0);
    chk("late.stall", {31'd0, stall}, 32'd0);
    chk_regs("late");

    // back-to-back store then fetch
    access("b2b_sw", 1'b0, 1'b1, 1'b0, 2'b00, 32'h0000_0080, 32'h1234_5678, 0, 32'h0);
    access("b2b_if", 1'b1, 1'b0, 1'b1, 2'b00, 32'h0000_0008, 32'h0, 0, 32'h8C01_0004);
    rd_req = 1'b0; wr_req = 1'b0;
    step();
    chk("end.stall", {31'd0, stall}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
